// File: rtl/aes_ctr_job_scheduler.sv
// Round-robin scheduler sharing one 16-lane AES-256-CTR batch engine between XOF (port 0) and PRF (port 1).
// Drives the engine mode, nonce, base counter and round, and buffers each finished batch in a one-entry valid/ready slot.
module aes_ctr_job_scheduler #(
    parameter int ROUNDS      = 15,
    parameter int XOF_BATCHES = 3,
    parameter int PRF_BATCHES = 1,
    parameter int BATCH_W     = 2048,
    parameter int CTR_STEP    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [31:0]        req_nonce,
    output logic [1:0]         ack,
    output logic               eng_mode,
    output logic [7:0]         eng_nonce_a,
    output logic [7:0]         eng_nonce_b,
    output logic [5:0]         eng_base_ctr,
    output logic [3:0]         eng_round,
    input  logic [BATCH_W-1:0] eng_data,
    output logic [BATCH_W-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_owner,
    output logic               out_last,
    output logic               busy
);
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);
    localparam logic [3:0] XOF_LAST   = 4'(XOF_BATCHES - 1);
    localparam logic [3:0] PRF_LAST   = 4'(PRF_BATCHES - 1);
    localparam logic [5:0] STEP       = 6'(CTR_STEP);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

    state_t     state, next_state;
    logic       rr_ptr;
    logic [3:0] batch_idx;
    logic       winner, grant, capture, advance;
    logic       round_end, buf_free, last_batch;

    // rr_ptr only breaks ties; a lone requester always wins.
    assign winner     = (req == 2'b11) ? rr_ptr : req[1];
    assign round_end  = (eng_round == LAST_ROUND);
    assign buf_free   = !out_valid || out_ready;
    assign last_batch = (batch_idx == (eng_mode ? PRF_LAST : XOF_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req != 2'b00) next_state = RUN;
            RUN, HOLD: begin
                if (round_end) begin
                    if (!buf_free)      next_state = HOLD;
                    else if (last_batch) next_state = IDLE;
                    else                next_state = RUN;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        grant   = 1'b0;
        capture = 1'b0;
        advance = 1'b0;
        busy    = 1'b1;
        case (state)
            IDLE: begin
                busy  = 1'b0;
                grant = (req != 2'b00);
            end
            RUN: begin
                advance = !round_end;
                capture = round_end && buf_free;
            end
            HOLD:    capture = buf_free;
            default: busy = 1'b0;
        endcase
    end

    // In HOLD neither branch fires, so round and base stay frozen for the engine.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack          <= 2'b00;
            rr_ptr       <= 1'b0;
            eng_mode     <= 1'b0;
            eng_nonce_a  <= 8'd0;
            eng_nonce_b  <= 8'd0;
            eng_base_ctr <= 6'd0;
            eng_round    <= 4'd0;
            batch_idx    <= 4'd0;
        end else begin
            ack <= 2'b00;
            if (grant) begin
                ack          <= winner ? 2'b10 : 2'b01;
                rr_ptr       <= ~winner;
                eng_mode     <= winner;
                eng_nonce_a  <= winner ? req_nonce[31:24] : req_nonce[15:8];
                eng_nonce_b  <= winner ? req_nonce[23:16] : req_nonce[7:0];
                eng_base_ctr <= 6'd0;
                eng_round    <= 4'd0;
                batch_idx    <= 4'd0;
            end else if (advance) begin
                eng_round <= eng_round + 4'd1;
            end else if (capture && !last_batch) begin
                eng_round    <= 4'd0;
                eng_base_ctr <= eng_base_ctr + STEP;
                batch_idx    <= batch_idx + 4'd1;
            end
        end
    end

    // A capture in the same cycle as a dequeue simply overwrites the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_owner <= 1'b0;
            out_last  <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= eng_data;
            out_owner <= eng_mode;
            out_last  <= last_batch;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_aes_ctr_job_scheduler.sv
// Bench for aes_ctr_job_scheduler: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed cycle offsets.
module tb_aes_ctr_job_scheduler;
    localparam int ROUNDS  = 15;
    localparam int BATCH_W = 2048;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         req = 2'b00;
    logic [31:0]        req_nonce = 32'd0;
    logic               out_ready = 1'b1;
    logic [1:0]         ack;
    logic               eng_mode;
    logic [7:0]         eng_nonce_a, eng_nonce_b;
    logic [5:0]         eng_base_ctr;
    logic [3:0]         eng_round;
    logic [BATCH_W-1:0] eng_data, out_data;
    logic               out_valid, out_owner, out_last, busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    aes_ctr_job_scheduler dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_nonce(req_nonce), .ack(ack),
        .eng_mode(eng_mode), .eng_nonce_a(eng_nonce_a), .eng_nonce_b(eng_nonce_b),
        .eng_base_ctr(eng_base_ctr), .eng_round(eng_round), .eng_data(eng_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_owner(out_owner), .out_last(out_last), .busy(busy)
    );

    // Stand-in engine: every lane encodes the inputs it was computed from.
    function automatic logic [BATCH_W-1:0] engine(input logic m, input logic [7:0] a, input logic [7:0] b,
                                                  input logic [5:0] base, input logic [3:0] rnd);
        logic [BATCH_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            r[i*128 +: 128] = {8'(i), a, b, 7'd0, m, 2'd0, base, 4'd0, rnd,
                               16'(i * 16 + int'(base)), 64'h0123_4567_89AB_CDEF};
        return r;
    endfunction

    assign eng_data = engine(eng_mode, eng_nonce_a, eng_nonce_b, eng_base_ctr, eng_round);

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s got %0h exp %0h", name, got, exp);
    endtask

    task automatic chk_data(input string name, input logic [BATCH_W-1:0] got, input logic [BATCH_W-1:0] exp);
        int lane = -1;
        checks++;
        for (int i = 15; i >= 0; i--)
            if (got[i*128 +: 128] !== exp[i*128 +: 128]) lane = i;
        if (lane < 0) passes++;
        else $display("FAIL %s lane %0d got %h exp %h", name, lane, got[lane*128 +: 128], exp[lane*128 +: 128]);
    endtask

    // Reference model: a job is a list of batches; round counts 0..ROUNDS-1 and waits at the end for a free slot.
    bit                 m_job, m_who, m_rr, m_bv, m_bown, m_blast;
    bit [1:0]           m_ack;
    bit [7:0]           m_na, m_nb;
    int                 m_base, m_round, m_batch;
    bit [BATCH_W-1:0]   m_bdata;
    bit                 s_free, s_cap, s_last, s_w;
    bit [BATCH_W-1:0]   s_data;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_job = 0; m_who = 0; m_rr = 0; m_bv = 0; m_bown = 0; m_blast = 0; m_ack = 0;
            m_na = 0; m_nb = 0; m_base = 0; m_round = 0; m_batch = 0; m_bdata = '0;
        end else begin
            s_free = !m_bv || out_ready;
            s_cap  = 0;
            s_last = 0;
            s_data = '0;
            m_ack  = 2'b00;
            if (!m_job) begin
                if (req != 2'b00) begin
                    s_w     = (req == 2'b11) ? m_rr : req[1];
                    m_ack   = s_w ? 2'b10 : 2'b01;
                    m_rr    = !s_w;
                    m_job   = 1;
                    m_who   = s_w;
                    m_na    = s_w ? req_nonce[31:24] : req_nonce[15:8];
                    m_nb    = s_w ? req_nonce[23:16] : req_nonce[7:0];
                    m_base  = 0; m_round = 0; m_batch = 0;
                end
            end else if (m_round < ROUNDS - 1) begin
                m_round++;
            end else if (s_free) begin
                s_cap  = 1;
                s_data = engine(m_who, m_na, m_nb, 6'(m_base), 4'(m_round));
                s_last = (m_batch == (m_who ? 1 : 3) - 1);
                if (s_last) m_job = 0;
                else begin
                    m_batch++;
                    m_round = 0;
                    m_base  = (m_base + 16) % 64;
                end
            end
            if (s_cap) begin
                m_bv = 1; m_bdata = s_data; m_bown = m_who; m_blast = s_last;
            end else if (m_bv && out_ready) begin
                m_bv = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("cmp_ack", 64'(ack), 64'(m_ack));
        chk("cmp_busy", 64'(busy), 64'(m_job));
        chk("cmp_out_valid", 64'(out_valid), 64'(m_bv));
        chk("cmp_round_max", 64'(eng_round <= 4'(ROUNDS - 1)), 64'(1));
        if (m_bv) begin
            chk_data("cmp_out_data", out_data, m_bdata);
            chk("cmp_out_meta", 64'({out_owner, out_last}), 64'({m_bown, m_blast}));
        end
        if (m_job) begin
            chk("cmp_eng_cfg", 64'({eng_mode, eng_nonce_a, eng_nonce_b}), 64'({m_who, m_na, m_nb}));
            chk("cmp_eng_ctr", 64'({eng_base_ctr, eng_round}), 64'({6'(m_base), 4'(m_round)}));
        end
    end

    // Record every batch the consumer actually takes.
    logic [BATCH_W-1:0] dq_data[$];
    bit                 dq_last[$];
    initial forever begin
        @(negedge clk);
        #2;
        if (out_valid && out_ready) begin
            dq_data.push_back(out_data);
            dq_last.push_back(out_last);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    logic [63:0] vmask, lmask, bmask;
    int          ak[3];
    logic [1:0]  av[3];
    int          n_ack;
    bit          ack_seen, nonce_bad;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", 64'({ack, busy, out_valid, out_owner, out_last, eng_mode}), 64'(0));
        chk("rst_eng", 64'({eng_nonce_a, eng_nonce_b, eng_base_ctr, eng_round}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // XOF only, consumer always ready
        req_nonce = 32'h0000_1234; req = 2'b01; vmask = 0; lmask = 0; bmask = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            vmask[k] = out_valid; lmask[k] = out_valid && out_last; bmask[k] = busy;
            if (k == 1) begin
                chk("t1_ack", 64'(ack), 64'(2'b01));
                chk("t1_start", 64'({eng_mode, eng_nonce_a, eng_nonce_b, eng_base_ctr, eng_round}),
                    64'({1'b0, 8'h12, 8'h34, 6'd0, 4'd0}));
                req = 2'b00;
            end
            if (k == 16) chk("t1_base16", 64'({eng_base_ctr, eng_round}), 64'({6'd16, 4'd0}));
            if (k == 31) chk("t1_base32", 64'({eng_base_ctr, eng_round}), 64'({6'd32, 4'd0}));
            if (k == 46) chk_data("t1_last_data", out_data, engine(1'b0, 8'h12, 8'h34, 6'd32, 4'd14));
        end
        chk("t1_valid_cycles", vmask, 64'h0000_4000_8001_0000);
        chk("t1_last_cycles", lmask, 64'h0000_4000_0000_0000);
        chk("t1_busy_cycles", bmask, 64'h0000_3FFF_FFFF_FFFE);

        // PRF only
        req_nonce = 32'hA53C_0000; req = 2'b10; vmask = 0; bmask = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            vmask[k] = out_valid; bmask[k] = busy;
            if (k == 1) begin
                chk("t2_ack", 64'(ack), 64'(2'b10));
                chk("t2_cfg", 64'({eng_mode, eng_nonce_a, eng_nonce_b}), 64'({1'b1, 8'hA5, 8'h3C}));
                req = 2'b00;
            end
            if (k == 16) chk("t2_owner_last", 64'({out_owner, out_last}), 64'(2'b11));
        end
        chk("t2_valid_cycles", vmask, 64'h0000_0000_0001_0000);
        chk("t2_busy_cycles", bmask, 64'h0000_0000_0000_FFFE);

        // Both requesting out of reset: alternate XOF, PRF, XOF
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; req_nonce = 32'h7788_1122; req = 2'b11; n_ack = 0;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (ack != 2'b00) begin
                if (n_ack < 3) begin ak[n_ack] = k; av[n_ack] = ack; end
                n_ack++;
                if (n_ack == 3) req = 2'b00;
            end
        end
        chk("t3_n_grants", 64'(n_ack), 64'(3));
        chk("t3_grants", 64'({8'(ak[0]), av[0], 8'(ak[1]), av[1], 8'(ak[2]), av[2]}),
            64'({8'd1, 2'b01, 8'd47, 2'b10, 8'd63, 2'b01}));

        // Backpressure during an XOF job
        dq_data.delete(); dq_last.delete();
        out_ready = 1'b0; req_nonce = 32'h0000_5A6B; req = 2'b01;
        for (int k = 1; k <= 65; k++) begin
            @(negedge clk);
            if (k == 1) req = 2'b00;
            if (k == 40) begin
                chk("t4_hold", 64'({busy, out_valid, eng_base_ctr, eng_round}), 64'({2'b11, 6'd16, 4'd14}));
                out_ready = 1'b1;
            end
            if (k == 41) begin
                chk("t4_resume", 64'({out_valid, eng_base_ctr, eng_round}), 64'({1'b1, 6'd32, 4'd0}));
                chk_data("t4_swap_data", out_data, engine(1'b0, 8'h5A, 8'h6B, 6'd16, 4'd14));
                out_ready = 1'b0;
            end
            if (k == 60) out_ready = 1'b1;
            if (k == 61) chk("t4_final", 64'({busy, out_valid, out_last}), 64'(3'b011));
            if (k == 62) chk("t4_drained", 64'(out_valid), 64'(0));
        end
        chk("t4_deq_n", 64'(dq_data.size()), 64'(3));
        for (int i = 0; i < 3; i++)
            if (i < dq_data.size()) begin
                chk_data($sformatf("t4_batch%0d", i), dq_data[i], engine(1'b0, 8'h5A, 8'h6B, 6'(16 * i), 4'd14));
                chk($sformatf("t4_last%0d", i), 64'(dq_last[i]), 64'(i == 2));
            end

        // Reset at round 7 of the second XOF batch, then a PRF job
        req_nonce = 32'hDEAD_BEEF; req = 2'b01;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            if (k == 1) req = 2'b00;
        end
        chk("t5_pre", 64'({eng_base_ctr, eng_round}), 64'({6'd16, 4'd7}));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_abort_outs", 64'({ack, busy, out_valid, out_owner, out_last, eng_mode}), 64'(0));
        chk("t5_abort_eng", 64'({eng_nonce_a, eng_nonce_b, eng_base_ctr, eng_round}), 64'(0));
        chk_data("t5_abort_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1; req = 2'b10; vmask = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            vmask[k] = out_valid;
            if (k == 1) begin
                chk("t5_ack", 64'({ack, eng_mode, eng_nonce_a, eng_nonce_b}), 64'({2'b10, 1'b1, 8'hDE, 8'hAD}));
                req = 2'b00;
            end
            if (k == 16) chk("t5_owner_last", 64'({out_owner, out_last}), 64'(2'b11));
        end
        chk("t5_valid_cycles", vmask, 64'h0000_0000_0001_0000);

        // Requests toggling while busy are ignored
        req_nonce = 32'h0000_C3D4; req = 2'b01; ack_seen = 0; nonce_bad = 0;
        for (int k = 1; k <= 48; k++) begin
            @(negedge clk);
            if (k == 1) chk("t6_ack", 64'(ack), 64'(2'b01));
            else if (ack != 2'b00) ack_seen = 1;
            if (k <= 45 && {eng_nonce_a, eng_nonce_b} != 16'hC3D4) nonce_bad = 1;
            if (k == 46) chk("t6_idle", 64'(busy), 64'(0));
            req = (k < 45) ? 2'(k) : 2'b00;
            req_nonce = $urandom();
        end
        chk("t6_no_ack_busy", 64'(ack_seen), 64'(0));
        chk("t6_nonce_stable", 64'(nonce_bad), 64'(0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/aes_ctr_job_scheduler.md
Name: aes_ctr_job_scheduler

Overview:
Controller that shares one 16-lane AES-256-CTR batch engine between two requesters: XOF (port 0) and PRF (port 1). It performs the following functions:
- Arbitrates job requests round-robin.
- Latches each job's nonce.
- Drives the engine's mode, nonce, base counter and round index.
- Captures each 2048-bit batch into a one-entry output buffer with valid/ready backpressure.
It sits between the sampler front-ends and the AES batch datapath; the datapath's free-running round counter is replaced by this block's eng_round.

Parameters:
ROUNDS, 15, engine cycles per batch (round indices 0..ROUNDS-1)
XOF_BATCHES, 3, batches per XOF job (48 blocks)
PRF_BATCHES, 1, batches per PRF job
BATCH_W, 2048, bits per batch (16 x 128)
CTR_STEP, 16, base-counter increment per batch

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req  input  2  job request; bit0 XOF, bit1 PRF; held high until ack
req_nonce  input  32  {nonce_a,nonce_b} per requester; [15:0] XOF, [31:16] PRF
ack  output  2  one-hot, one-cycle grant pulse
eng_mode  output  1  0 XOF, 1 PRF
eng_nonce_a  output  8  latched nonce_a
eng_nonce_b  output  8  latched nonce_b
eng_base_ctr  output  6  base counter of current batch
eng_round  output  4  round index driven to engine and key expansion
eng_data  input  BATCH_W  engine output, valid when eng_round==ROUNDS-1
out_data  output  BATCH_W  buffered batch
out_valid  output  1  buffer full
out_ready  input  1  consumer accepts
out_owner  output  1  requester of the buffered batch
out_last  output  1  buffered batch is the job's final batch
busy  output  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; rr_ptr=0 (XOF preferred).
- States:
  - IDLE: no job active.
  - RUN: round counter advancing.
  - HOLD: round frozen at ROUNDS-1 waiting for the buffer.
- IDLE arbitration: if req!=0 at edge T, grant is decided at that edge.
  - Single request: that requester wins.
  - Both requesting: winner = rr_ptr.
  - After a grant, rr_ptr = ~winner.
- Timing of a grant at edge T, effective cycle T+1:
  - ack[winner]=1 for exactly that cycle.
  - Nonce, mode and owner are latched.
  - eng_base_ctr=0, eng_round=0, batch_idx=0, state=RUN.
- RUN: eng_round increments each cycle. At eng_round==ROUNDS-1 the engine data is captured in the same cycle, provided the buffer is free or being dequeued (out_valid&&out_ready).
  - If the batch was not the last: eng_round->0, eng_base_ctr+=CTR_STEP (6-bit wrap, mod 64), batch_idx++.
  - If it was the last (batch_idx==N-1, N by mode): state->IDLE.
  - If the buffer is full and not dequeued: state->HOLD, round and base are frozen, engine inputs are held stable.
- HOLD: capture on the first cycle the buffer frees; the transition is then identical to the RUN capture.
- Output buffer:
  - On capture: out_valid=1 next cycle, out_data=eng_data, out_owner=owner, out_last=(last batch).
  - Cleared on out_valid&&out_ready unless refilled in the same cycle.
  - Simultaneous dequeue and capture: the new batch replaces the old with no bubble and no loss.
- Latency with out_ready=1: req sampled at T -> first out_valid at T+16; subsequent batches every ROUNDS cycles.
- IDLE re-entry: a new grant is possible at the first edge after returning to IDLE, so at least one cycle idles between jobs.
- Requests that change while a job runs are ignored until IDLE; ack is never issued while busy.
- Reset mid-job: asynchronous abort. State returns to IDLE, the buffer is emptied, rr_ptr=0, and no ack or out_valid glitches after release.
- Invariant: eng_round never exceeds ROUNDS-1.

Test Plan:
1. XOF only, out_ready=1, req[0] high at T:
   - ack=01 at T+1.
   - eng_base_ctr 0,16,32 at round 0 of each batch.
   - out_valid at T+16, T+31, T+46; out_last only on the third.
   - busy falls at T+46.
2. PRF only, nonce 0xA5_3C:
   - eng_mode=1, eng_nonce_a=A5, eng_nonce_b=3C.
   - Single batch with out_last=1, out_owner=1.
   - Back to IDLE after 15 RUN cycles.
3. req=11 out of reset:
   - XOF granted first (ack=01).
   - PRF granted on the first edge after the XOF job ends.
   - With both held continuously, grants alternate XOF, PRF, XOF.
4. Backpressure, out_ready=0 during an XOF job:
   - First batch captured.
   - Second batch holds with eng_round=14 and base=16 frozen.
   - Raising out_ready for one cycle gives dequeue+capture in the same cycle; no batch is lost or duplicated (compare all 3 batches against the golden model).
5. rst_n asserted at round 7 of the second XOF batch:
   - All outputs 0 immediately.
   - After release with req=10: PRF is granted and the job runs cleanly.
6. req dropped and re-raised while busy:
   - No ack until IDLE.
   - eng_nonce values stay unchanged throughout the job.
